// File: rtl/sram_obi_pkg.sv
// Shared types and address-window helpers for the SRAM data-side OBI arbiter.
package sram_obi_pkg;

  localparam logic [31:0] SRAM_BASE_ADDR_DEF = 32'h8000_0000;
  localparam logic [31:0] SRAM_END_ADDR_DEF  = 32'h8000_C000;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_rsp_t;

  // The window is half-open: lim is the first address outside the SRAM.
  function automatic logic in_sram_window(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] lim);
    return (addr >= base) && (addr < lim);
  endfunction

endpackage

// File: rtl/owner_fifo.sv
// Small FIFO of master indices recording who owns each outstanding SRAM transaction.
module owner_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wrap_inc(wr_ptr);
      if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sram_obi_arbiter.sv
// Round-robin arbiter sharing one SRAM OBI data port between several masters,
// with local error responses for accesses outside the SRAM window.
module sram_obi_arbiter
  import sram_obi_pkg::*;
#(
  parameter int          NUM_MASTERS     = 2,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] SRAM_BASE_ADDR  = SRAM_BASE_ADDR_DEF,
  parameter logic [31:0] SRAM_END_ADDR   = SRAM_END_ADDR_DEF
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_MASTERS-1:0]       m_req_i,
  output logic [NUM_MASTERS-1:0]       m_gnt_o,
  input  logic [NUM_MASTERS-1:0][31:0] m_addr_i,
  input  logic [NUM_MASTERS-1:0]       m_we_i,
  input  logic [NUM_MASTERS-1:0][3:0]  m_be_i,
  input  logic [NUM_MASTERS-1:0][31:0] m_wdata_i,
  output logic [NUM_MASTERS-1:0]       m_rvalid_o,
  output logic [NUM_MASTERS-1:0][31:0] m_rdata_o,
  output logic [NUM_MASTERS-1:0]       m_err_o,
  output logic                         s_req_o,
  input  logic                         s_gnt_i,
  output logic [31:0]                  s_addr_o,
  output logic                         s_we_o,
  output logic [3:0]                   s_be_o,
  output logic [31:0]                  s_wdata_o,
  input  logic                         s_rvalid_i,
  input  logic [31:0]                  s_rdata_i,
  output logic                         illegal_memory_o,
  output logic                         protocol_err_o
);

  localparam int IW = $clog2(NUM_MASTERS);

  obi_req_t      reqs [NUM_MASTERS];
  obi_req_t      win_req;
  obi_rsp_t      rsp;
  logic [IW-1:0] ptr_q, winner, idx, head, rsp_owner, err_owner_q;
  logic          found, win_legal, fifo_full, fifo_empty;
  logic          s_req, fwd_hs, ill_acc, hs, rsp_pop, rsp_valid;
  logic          err_pend_q, perr_q;
  logic [1:0]    blank_q;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= NUM_MASTERS) s -= NUM_MASTERS;
    return IW'(s);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      reqs[i] = '{addr: m_addr_i[i], we: m_we_i[i], be: m_be_i[i], wdata: m_wdata_i[i]};
    end
  end

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = wrap_add(ptr_q, i);
      if (!found && m_req_i[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign win_req   = reqs[winner];
  assign win_legal = in_sram_window(win_req.addr, SRAM_BASE_ADDR, SRAM_END_ADDR);

  // Illegal requests wait for an empty FIFO so their error response stays in order.
  assign s_req   = rst_ni & found & win_legal & ~fifo_full & ~err_pend_q;
  assign fwd_hs  = s_req & s_gnt_i;
  assign ill_acc = rst_ni & found & ~win_legal & fifo_empty & ~err_pend_q;
  assign hs      = fwd_hs | ill_acc;
  assign rsp_pop = rst_ni & s_rvalid_i & ~fifo_empty;

  assign s_req_o          = s_req;
  assign s_addr_o         = s_req ? win_req.addr  : '0;
  assign s_we_o           = s_req ? win_req.we    : 1'b0;
  assign s_be_o           = s_req ? win_req.be    : '0;
  assign s_wdata_o        = s_req ? win_req.wdata : '0;
  assign m_gnt_o          = hs ? (NUM_MASTERS'(1) << winner) : '0;
  assign illegal_memory_o = ill_acc;
  assign protocol_err_o   = perr_q;

  owner_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IW)
  ) u_owner_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (fwd_hs),
    .pop       (rsp_pop),
    .push_data (winner),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  always_comb begin
    rsp       = '0;
    rsp_valid = 1'b0;
    rsp_owner = err_owner_q;
    if (rsp_pop) begin
      rsp_valid = 1'b1;
      rsp_owner = head;
      rsp.rdata = s_rdata_i;
    end else if (rst_ni && err_pend_q) begin
      rsp_valid = 1'b1;
      rsp.err   = 1'b1;
    end
  end

  always_comb begin
    m_rvalid_o = '0;
    m_err_o    = '0;
    for (int i = 0; i < NUM_MASTERS; i++) m_rdata_o[i] = rsp.rdata;
    if (rsp_valid) begin
      m_rvalid_o[rsp_owner] = 1'b1;
      m_err_o[rsp_owner]    = rsp.err;
    end
  end

  // blank_q masks stale SRAM responses that arrive just after a reset dropped their owners.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      err_pend_q  <= 1'b0;
      err_owner_q <= '0;
      blank_q     <= 2'd2;
      perr_q      <= 1'b0;
    end else begin
      if (hs)      ptr_q       <= wrap_add(winner, 1);
      err_pend_q <= ill_acc;
      if (ill_acc) err_owner_q <= winner;
      if (blank_q != '0) blank_q <= blank_q - 1'b1;
      if (s_rvalid_i && fifo_empty && blank_q == '0) perr_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_obi_arbiter.sv
// Directed bench for sram_obi_arbiter: expected responses queued at stimulus time,
// compared by an independent monitor whenever any m_rvalid_o bit rises.
module tb_sram_obi_arbiter;

  localparam int N = 2;

  logic                clk = 1'b0;
  logic                rst_ni;
  logic [N-1:0]        m_req_i;
  logic [N-1:0]        m_gnt_o;
  logic [N-1:0][31:0]  m_addr_i;
  logic [N-1:0]        m_we_i;
  logic [N-1:0][3:0]   m_be_i;
  logic [N-1:0][31:0]  m_wdata_i;
  logic [N-1:0]        m_rvalid_o;
  logic [N-1:0][31:0]  m_rdata_o;
  logic [N-1:0]        m_err_o;
  logic                s_req_o;
  logic                s_gnt_i;
  logic [31:0]         s_addr_o;
  logic                s_we_o;
  logic [3:0]          s_be_o;
  logic [31:0]         s_wdata_o;
  logic                s_rvalid_i;
  logic [31:0]         s_rdata_i;
  logic                illegal_memory_o;
  logic                protocol_err_o;

  typedef struct {
    int          m;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb [$];
  int   errors = 0;
  int   checks = 0;

  sram_obi_arbiter #(
    .NUM_MASTERS     (N),
    .MAX_OUTSTANDING (2),
    .SRAM_BASE_ADDR  (32'h8000_0000),
    .SRAM_END_ADDR   (32'h8000_C000)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .m_req_i          (m_req_i),
    .m_gnt_o          (m_gnt_o),
    .m_addr_i         (m_addr_i),
    .m_we_i           (m_we_i),
    .m_be_i           (m_be_i),
    .m_wdata_i        (m_wdata_i),
    .m_rvalid_o       (m_rvalid_o),
    .m_rdata_o        (m_rdata_o),
    .m_err_o          (m_err_o),
    .s_req_o          (s_req_o),
    .s_gnt_i          (s_gnt_i),
    .s_addr_o         (s_addr_o),
    .s_we_o           (s_we_o),
    .s_be_o           (s_be_o),
    .s_wdata_o        (s_wdata_o),
    .s_rvalid_i       (s_rvalid_i),
    .s_rdata_i        (s_rdata_i),
    .illegal_memory_o (illegal_memory_o),
    .protocol_err_o   (protocol_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_rsp(input int m, input logic [31:0] d, input logic e);
    exp_t x;
    x.m     = m;
    x.rdata = d;
    x.err   = e;
    sb.push_back(x);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive(input int m, input logic r, input logic [31:0] a,
                       input logic we, input logic [3:0] be, input logic [31:0] wd);
    m_req_i[m]   = r;
    m_addr_i[m]  = a;
    m_we_i[m]    = we;
    m_be_i[m]    = be;
    m_wdata_i[m] = wd;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},    m_gnt_o, 0);
    chk({tag, "_sreq"},   s_req_o, 0);
    chk({tag, "_saddr"},  s_addr_o, 0);
    chk({tag, "_rvalid"}, m_rvalid_o, 0);
    chk({tag, "_err"},    m_err_o, 0);
    chk({tag, "_ill"},    illegal_memory_o, 0);
    chk({tag, "_perr"},   protocol_err_o, 0);
  endtask

  // Monitor: every response seen on the master side must match the queue head.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (m_rvalid_o != '0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid: got rvalid=%b with nothing expected", m_rvalid_o);
        end else begin
          x = sb.pop_front();
          chk("rsp_owner", m_rvalid_o, 64'(1) << x.m);
          chk("rsp_rdata", m_rdata_o[x.m], x.rdata);
          chk("rsp_err",   m_err_o, x.err ? (64'(1) << x.m) : 64'(0));
        end
      end
    end
  end

  initial begin
    int prev_m;
    rst_ni     = 1'b0;
    m_req_i    = '0;
    m_addr_i   = '0;
    m_we_i     = '0;
    m_be_i     = '0;
    m_wdata_i  = '0;
    s_gnt_i    = 1'b0;
    s_rvalid_i = 1'b0;
    s_rdata_i  = '0;
    prev_m     = 0;

    cyc();
    cyc();
    smp();
    chk_all_zero("reset");
    cyc();
    rst_ni = 1'b1;
    smp();
    chk_all_zero("post_reset");

    // 1: single legal read from master 0
    cyc();
    drive(0, 1'b1, 32'h8000_0010, 1'b0, 4'hF, 32'h0);
    s_gnt_i = 1'b1;
    smp();
    chk("t1_gnt",   m_gnt_o, 2'b01);
    chk("t1_sreq",  s_req_o, 1);
    chk("t1_saddr", s_addr_o, 32'h8000_0010);
    chk("t1_swe",   s_we_o, 0);
    chk("t1_sbe",   s_be_o, 4'hF);
    cyc();
    drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    expect_rsp(0, 32'hDEAD_BEEF, 1'b0);
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'hDEAD_BEEF;
    smp();
    chk("t1_rvalid", m_rvalid_o, 2'b01);
    chk("t1_rdata",  m_rdata_o[0], 32'hDEAD_BEEF);
    chk("t1_err",    m_err_o, 0);

    // 2: both masters request continuously; pointer is 1 after test 1
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (i == 0) begin
        drive(0, 1'b1, 32'h8000_0100, 1'b0, 4'hF, 32'h0);
        drive(1, 1'b1, 32'h8000_0200, 1'b0, 4'hF, 32'h0);
        s_rvalid_i = 1'b0;
      end else begin
        expect_rsp(prev_m, 32'hA000_0000 + 32'(i - 1), 1'b0);
        s_rvalid_i = 1'b1;
        s_rdata_i  = 32'hA000_0000 + 32'(i - 1);
      end
      smp();
      chk("t2_rr_gnt", m_gnt_o, (i % 2 == 0) ? 2'b10 : 2'b01);
      prev_m = (i % 2 == 0) ? 1 : 0;
    end
    cyc();
    drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    drive(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    expect_rsp(prev_m, 32'hA000_0005, 1'b0);
    s_rdata_i = 32'hA000_0005;
    smp();
    chk("t2_idle_gnt", m_gnt_o, 0);
    cyc();
    s_rvalid_i = 1'b0;

    // 3: SRAM stalls, then the owner FIFO fills to MAX_OUTSTANDING
    drive(0, 1'b1, 32'h8000_0300, 1'b0, 4'hF, 32'h0);
    drive(1, 1'b1, 32'h8000_0304, 1'b0, 4'hF, 32'h0);
    s_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("t3_stall_gnt",  m_gnt_o, 0);
      chk("t3_stall_sreq", s_req_o, 1);
      chk("t3_stall_addr", s_addr_o, 32'h8000_0304);
      cyc();
    end
    s_gnt_i = 1'b1;
    smp();
    chk("t3_hs1", m_gnt_o, 2'b10);
    cyc();
    smp();
    chk("t3_hs2", m_gnt_o, 2'b01);
    for (int i = 0; i < 2; i++) begin
      cyc();
      smp();
      chk("t3_full_sreq", s_req_o, 0);
      chk("t3_full_gnt",  m_gnt_o, 0);
    end
    cyc();
    expect_rsp(1, 32'h1111_0001, 1'b0);
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'h1111_0001;
    smp();
    chk("t3_pop_gnt", m_gnt_o, 0);
    cyc();
    drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    s_gnt_i = 1'b0;
    expect_rsp(0, 32'h2222_0002, 1'b0);
    s_rdata_i = 32'h2222_0002;
    smp();
    chk("t3_room_sreq", s_req_o, 1);
    cyc();
    drive(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    s_rvalid_i = 1'b0;

    // 4: out-of-window write from master 1 (first illegal address)
    cyc();
    drive(1, 1'b1, 32'h8000_C000, 1'b1, 4'hF, 32'h5555_AAAA);
    s_gnt_i = 1'b1;
    expect_rsp(1, 32'h0, 1'b1);
    smp();
    chk("t4_gnt",  m_gnt_o, 2'b10);
    chk("t4_ill",  illegal_memory_o, 1);
    chk("t4_sreq", s_req_o, 0);
    cyc();
    drive(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    smp();
    chk("t4_rvalid", m_rvalid_o, 2'b10);
    chk("t4_err",    m_err_o, 2'b10);
    chk("t4_rdata",  m_rdata_o[1], 0);
    chk("t4_ill_off", illegal_memory_o, 0);

    // 5: illegal request waits behind an outstanding legal write
    cyc();
    drive(1, 1'b1, 32'h8000_0400, 1'b1, 4'b0011, 32'hCAFE_F00D);
    smp();
    chk("t5_wr_gnt",   m_gnt_o, 2'b10);
    chk("t5_wr_we",    s_we_o, 1);
    chk("t5_wr_be",    s_be_o, 4'b0011);
    chk("t5_wr_wdata", s_wdata_o, 32'hCAFE_F00D);
    cyc();
    drive(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    drive(0, 1'b1, 32'h7FFF_FFFC, 1'b0, 4'hF, 32'h0);
    for (int i = 0; i < 2; i++) begin
      smp();
      chk("t5_wait_gnt", m_gnt_o, 0);
      chk("t5_wait_ill", illegal_memory_o, 0);
      chk("t5_wait_sreq", s_req_o, 0);
      cyc();
    end
    expect_rsp(1, 32'h0, 1'b0);
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'h0;
    smp();
    chk("t5_pop_gnt", m_gnt_o, 0);
    cyc();
    s_rvalid_i = 1'b0;
    expect_rsp(0, 32'h0, 1'b1);
    smp();
    chk("t5_ill_gnt", m_gnt_o, 2'b01);
    chk("t5_ill",     illegal_memory_o, 1);
    cyc();
    drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    smp();
    chk("t5_err_rvalid", m_rvalid_o, 2'b01);
    chk("t5_err",        m_err_o, 2'b01);

    // 6: reset with two outstanding, stale responses, then a stray response
    cyc();
    drive(0, 1'b1, 32'h8000_0800, 1'b0, 4'hF, 32'h0);
    drive(1, 1'b1, 32'h8000_0900, 1'b0, 4'hF, 32'h0);
    smp();
    chk("t6_hs1", m_gnt_o, 2'b10);
    cyc();
    smp();
    chk("t6_hs2", m_gnt_o, 2'b01);
    cyc();
    rst_ni     = 1'b0;
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'h3333_3333;
    smp();
    chk_all_zero("t6_in_reset");
    cyc();
    rst_ni = 1'b1;
    drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    drive(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    s_gnt_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      smp();
      chk("t6_stale_rvalid", m_rvalid_o, 0);
      chk("t6_stale_perr",   protocol_err_o, 0);
      cyc();
    end
    s_rvalid_i = 1'b0;
    smp();
    chk("t6_quiet_perr", protocol_err_o, 0);
    cyc();
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'h4444_4444;
    smp();
    chk("t6_stray_rvalid", m_rvalid_o, 0);
    cyc();
    s_rvalid_i = 1'b0;
    smp();
    chk("t6_perr_set", protocol_err_o, 1);
    cyc();
    drive(0, 1'b1, 32'h8000_0A00, 1'b0, 4'hF, 32'h0);
    drive(1, 1'b1, 32'h8000_0B00, 1'b0, 4'hF, 32'h0);
    s_gnt_i = 1'b1;
    smp();
    chk("t6_ptr_reset_gnt", m_gnt_o, 2'b01);
    chk("t6_perr_sticky",   protocol_err_o, 1);
    cyc();
    drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    drive(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    s_gnt_i = 1'b0;
    expect_rsp(0, 32'h5555_0005, 1'b0);
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'h5555_0005;
    smp();
    chk("t6_final_rvalid", m_rvalid_o, 2'b01);
    cyc();
    s_rvalid_i = 1'b0;
    smp();
    chk("t6_perr_still", protocol_err_o, 1);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
